// File: rtl/register_pkg.sv
// Shared types for the registered-ready skid slice.
// The state encoding doubles as the occupancy count driven on the count port.
package register_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : register_pkg

// File: rtl/register_skid.sv
// Valid/ready slice with a two-entry (main + skid) buffer that registers the ready path,
// so s_ready never depends combinationally on m_ready.
module register_skid
   import register_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       count
);

   // Handshake rule: a beat moves on a rising edge where valid and ready are both high.
   // Once m_valid rises it stays high with m_data stable until m_ready takes the beat.

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept;
   logic             deliver;

   // Only reset bypasses the flops, so the slice is ready again the cycle reset drops.
   assign s_ready = !reset && (state_q != FULL);
   assign m_valid = (state_q != EMPTY);
   assign m_data  = main_q;
   assign count   = state_q;

   assign accept  = s_valid && s_ready;
   assign deliver = m_valid && m_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = BUSY;
               main_d  = s_data;
            end
         end
         BUSY: begin
            if (accept && deliver) begin
               main_d = s_data;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = s_data;
            end else if (deliver) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (deliver) begin
               state_d = BUSY;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // A stalled output beat must not change underneath the consumer.
   a_stall_stable : assert property (@(posedge clk) disable iff (reset)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule : register_skid
